// File: rtl/adc_sampler_if.sv
// Serial ADC pins plus the sample/strobe outputs that feed the derivative stage.
interface adc_sampler_if #(
    parameter int N = 16
);
    logic                sdata;
    logic                cs_n;
    logic                sclk;
    logic signed [N-1:0] yk;
    logic                sample_valid;
    logic                en2;
    logic                en1;
    logic                overrun;

    // Sampler side: drives the ADC control pins and the sample outputs.
    modport master (
        input  sdata,
        output cs_n, sclk, yk, sample_valid, en2, en1, overrun
    );

    // ADC / downstream side.
    modport slave (
        output sdata,
        input  cs_n, sclk, yk, sample_valid, en2, en1, overrun
    );
endinterface

// File: rtl/adc_sampler.sv
// Serial ADC front end: periodic conversion, offset-binary to signed fixed-point,
// and en2/en1 sequencing strobes for the downstream derivative pipeline.
module adc_sampler #(
    parameter int N             = 16,
    parameter int FRAC_SHIFT    = 4,
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 10000
) (
    input  logic          clk,
    input  logic          reset,
    adc_sampler_if.master bus
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PER_MAX = PW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD,
        ST_STROBE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_period;
    logic [DW-1:0]       r_div;
    logic [4:0]          r_bits;
    logic [2:0]          r_strb;
    // Only the last 12 bits shifted in are kept; the 4 leading bits fall off the top.
    logic [11:0]         r_shift;
    logic                r_cs_n;
    logic                r_sclk;
    logic signed [N-1:0] r_yk;
    logic                r_sv;
    logic                r_en1;
    logic                r_en2;
    logic                r_overrun;

    logic                w_tick;
    logic signed [11:0]  w_code_s;
    logic signed [N-1:0] w_ext;
    logic signed [N-1:0] w_yk;

    assign w_tick   = (r_period == '0);
    assign w_code_s = {~r_shift[11], r_shift[10:0]};
    assign w_ext    = N'(w_code_s);
    assign w_yk     = w_ext <<< FRAC_SHIFT;

    assign bus.cs_n         = r_cs_n;
    assign bus.sclk         = r_sclk;
    assign bus.yk           = r_yk;
    assign bus.sample_valid = r_sv;
    assign bus.en2          = r_en2;
    assign bus.en1          = r_en1;
    assign bus.overrun      = r_overrun;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: start on tick, load after 16 sclk rises, strobe for 4 cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_tick) w_state_nxt = ST_CONV;
            ST_CONV:   if (r_bits == 5'd16) w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_STROBE;
            ST_STROBE: if (r_strb == 3'd3) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Free-running sample period counter and sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_period <= (r_period == PER_MAX) ? '0 : r_period + 1'b1;
            if (w_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
        end
    end

    // Serial capture, sample conversion and downstream strobes, all registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b1;
            r_div   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_strb  <= '0;
            r_yk    <= '0;
            r_sv    <= 1'b0;
            r_en1   <= 1'b0;
            r_en2   <= 1'b0;
        end else begin
            r_sv  <= 1'b0;
            r_en1 <= 1'b0;
            r_en2 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_cs_n <= 1'b0;
                        r_sclk <= 1'b1;
                        r_div  <= '0;
                        r_bits <= '0;
                    end
                end
                ST_CONV: begin
                    if (r_bits == 5'd16) begin
                        r_cs_n <= 1'b1;
                        r_sclk <= 1'b1;
                        r_yk   <= w_yk;
                        r_sv   <= 1'b1;
                    end else if (r_div == DIV_MAX) begin
                        r_div  <= '0;
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_shift <= {r_shift[10:0], bus.sdata};
                            r_bits  <= r_bits + 5'd1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_strb <= '0;
                end
                ST_STROBE: begin
                    r_strb <= r_strb + 3'd1;
                    if (r_strb == 3'd1) r_en2 <= 1'b1;
                    if (r_strb == 3'd2) r_en1 <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_sampler.sv
// Self-checking bench for adc_sampler: ADC serial model, yk scoreboard, strobe timing.
module tb_adc_sampler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc++;

    adc_sampler_if #(.N(16)) bus_a ();
    adc_sampler_if #(.N(16)) bus_b ();

    adc_sampler #(.N(16), .FRAC_SHIFT(4), .CLK_DIV(2), .SAMPLE_PERIOD(100)) u_dut (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    adc_sampler #(.N(16), .FRAC_SHIFT(4), .CLK_DIV(2), .SAMPLE_PERIOD(50)) u_ovr (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    // ADC models: present word bit (15-idx) and advance on each sclk rise.
    logic [15:0] word_a = 16'h0;
    logic [15:0] word_b = 16'h0;
    int          idx_a  = 16;
    int          idx_b  = 16;

    always @(negedge bus_a.cs_n) idx_a = 0;
    always @(posedge bus_a.sclk) if (bus_a.cs_n === 1'b0) idx_a++;
    assign bus_a.sdata = (idx_a < 16) ? word_a[15-idx_a] : 1'b0;

    always @(negedge bus_b.cs_n) idx_b = 0;
    always @(posedge bus_b.sclk) if (bus_b.cs_n === 1'b0) idx_b++;
    assign bus_b.sdata = (idx_b < 16) ? word_b[15-idx_b] : 1'b0;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    function automatic logic [15:0] model(input logic [11:0] code);
        int v;
        v = (int'(code) - 2048) * 16;
        return v[15:0];
    endfunction

    // Event monitor for bus_a, sampled on the falling clock edge.
    logic pcs_a   = 1'b1;
    logic psclk_a = 1'b1;
    int   rises_a = 0, ffall_a = -1, frise_a = -1;
    int   sv_cnt_a = 0, en1_cnt_a = 0, en2_cnt_a = 0;
    int   en1_at_a = -1, en2_at_a = -1, both_a = 0;

    always @(negedge clk) begin
        if (pcs_a === 1'b1 && bus_a.cs_n === 1'b0) begin
            rises_a = 0; ffall_a = -1; frise_a = -1;
        end
        if (psclk_a === 1'b1 && bus_a.sclk === 1'b0 && ffall_a < 0) ffall_a = cyc;
        if (psclk_a === 1'b0 && bus_a.sclk === 1'b1 && bus_a.cs_n === 1'b0) begin
            rises_a++;
            if (frise_a < 0) frise_a = cyc;
        end
        if (bus_a.sample_valid === 1'b1) sv_cnt_a++;
        if (bus_a.en1 === 1'b1) begin en1_cnt_a++; en1_at_a = cyc; end
        if (bus_a.en2 === 1'b1) begin en2_cnt_a++; en2_at_a = cyc; end
        if (bus_a.en1 === 1'b1 && bus_a.en2 === 1'b1) both_a++;
        pcs_a   = bus_a.cs_n;
        psclk_a = bus_a.sclk;
    end

    int s_a     = 0;
    int last_sv = 0;

    task automatic wait_sv_a(input int budget, output int at, output bit ok);
        ok = 1'b0; at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.sample_valid === 1'b1) begin at = cyc; ok = 1'b1; break; end
        end
    endtask

    task automatic wait_sv_b(input int budget, output int at, output bit ok);
        ok = 1'b0; at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_b.sample_valid === 1'b1) begin at = cyc; ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset_a = 1'b1;
        reset_b = 1'b1;
        word_a  = 16'h0800;
        exp_a.push_back(model(12'h800));
        repeat (5) @(negedge clk);
        n_cmp++; if (bus_a.cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", bus_a.cs_n); end
        n_cmp++; if (bus_a.sclk !== 1'b1) begin n_bad++; $display("FAIL rst_sclk: got %b want 1", bus_a.sclk); end
        n_cmp++; if (bus_a.yk !== 16'h0000) begin n_bad++; $display("FAIL rst_yk: got %h want 0000", bus_a.yk); end
        n_cmp++; if (bus_a.sample_valid !== 1'b0) begin n_bad++; $display("FAIL rst_sv: got %b want 0", bus_a.sample_valid); end
        n_cmp++; if (bus_a.en1 !== 1'b0) begin n_bad++; $display("FAIL rst_en1: got %b want 0", bus_a.en1); end
        n_cmp++; if (bus_a.en2 !== 1'b0) begin n_bad++; $display("FAIL rst_en2: got %b want 0", bus_a.en2); end
        n_cmp++; if (bus_a.overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b want 0", bus_a.overrun); end
        reset_a = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_a.cs_n !== 1'b0) begin n_bad++; $display("FAIL first_cs_fall: got %b want 0", bus_a.cs_n); end
        s_a = cyc;
    endtask

    task automatic test_midscale;
        int at; bit ok; logic [15:0] e;
        wait_sv_a(200, at, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL mid_sv_timeout: got none want cycle %0d", s_a + 65); end
        else begin
            if (at !== s_a + 65) begin n_bad++; $display("FAIL mid_sv_time: got %0d want %0d", at, s_a + 65); end
            e = exp_a.pop_front();
            n_cmp++; if (bus_a.yk !== e) begin n_bad++; $display("FAIL mid_yk: got %h want %h", bus_a.yk, e); end
        end
        last_sv = at;
        word_a = 16'h0FFF;
        exp_a.push_back(model(12'hFFF));
        while (cyc < s_a + 70) @(negedge clk);
        n_cmp++; if (ffall_a !== s_a + 2) begin n_bad++; $display("FAIL sclk_first_fall: got %0d want %0d", ffall_a, s_a + 2); end
        n_cmp++; if (frise_a !== s_a + 4) begin n_bad++; $display("FAIL sclk_first_rise: got %0d want %0d", frise_a, s_a + 4); end
        n_cmp++; if (rises_a !== 16) begin n_bad++; $display("FAIL sclk_rises: got %0d want 16", rises_a); end
        n_cmp++; if (en2_at_a !== s_a + 68) begin n_bad++; $display("FAIL en2_time: got %0d want %0d", en2_at_a, s_a + 68); end
        n_cmp++; if (en1_at_a !== s_a + 69) begin n_bad++; $display("FAIL en1_time: got %0d want %0d", en1_at_a, s_a + 69); end
        n_cmp++; if (en1_cnt_a !== 1 || en2_cnt_a !== 1) begin n_bad++; $display("FAIL strobe_count: got en1=%0d en2=%0d want 1/1", en1_cnt_a, en2_cnt_a); end
        n_cmp++; if (both_a !== 0) begin n_bad++; $display("FAIL en_overlap: got %0d want 0", both_a); end
        n_cmp++; if (bus_a.cs_n !== 1'b1) begin n_bad++; $display("FAIL cs_idle: got %b want 1", bus_a.cs_n); end
    endtask

    task automatic test_full_zero;
        int at; bit ok; logic [15:0] e;
        for (int k = 0; k < 2; k++) begin
            wait_sv_a(150, at, ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL fz_sv_timeout[%0d]: got none want pulse", k); end
            else begin
                if (at - last_sv !== 100) begin n_bad++; $display("FAIL fz_spacing[%0d]: got %0d want 100", k, at - last_sv); end
                e = exp_a.pop_front();
                n_cmp++; if (bus_a.yk !== e) begin n_bad++; $display("FAIL fz_yk[%0d]: got %h want %h", k, bus_a.yk, e); end
            end
            last_sv = at;
            if (k == 0) begin word_a = 16'h0000; exp_a.push_back(model(12'h000)); end
        end
        word_a = 16'hF123;
        exp_a.push_back(model(12'h123));
    endtask

    task automatic test_leading_bits;
        int at; bit ok; logic [15:0] e;
        wait_sv_a(150, at, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL lead_sv_timeout: got none want pulse"); end
        else begin
            e = exp_a.pop_front();
            if (bus_a.yk !== e) begin n_bad++; $display("FAIL lead_yk: got %h want %h", bus_a.yk, e); end
        end
        last_sv = at;
    endtask

    task automatic test_reset_mid;
        int s2, s3, at, sv0, e1, e2; bit ok; logic [15:0] e;
        word_a = 16'h0ABC;
        s2 = -1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus_a.cs_n === 1'b0) begin s2 = cyc; break; end
        end
        n_cmp++; if (s2 < 0) begin n_bad++; $display("FAIL rm_start_timeout: got none want cs_n fall"); end
        repeat (30) @(negedge clk);
        sv0 = sv_cnt_a; e1 = en1_cnt_a; e2 = en2_cnt_a;
        reset_a = 1'b1;
        #1;
        n_cmp++; if (bus_a.cs_n !== 1'b1) begin n_bad++; $display("FAIL rm_cs_n: got %b want 1", bus_a.cs_n); end
        n_cmp++; if (bus_a.yk !== 16'h0000) begin n_bad++; $display("FAIL rm_yk: got %h want 0000", bus_a.yk); end
        n_cmp++; if (bus_a.sclk !== 1'b1) begin n_bad++; $display("FAIL rm_sclk: got %b want 1", bus_a.sclk); end
        repeat (3) @(negedge clk);
        word_a = 16'h0456;
        exp_a.push_back(model(12'h456));
        reset_a = 1'b0;
        n_cmp++;
        if (sv_cnt_a !== sv0 || en1_cnt_a !== e1 || en2_cnt_a !== e2) begin
            n_bad++; $display("FAIL rm_no_strobes: got sv=%0d en1=%0d en2=%0d want %0d/%0d/%0d",
                              sv_cnt_a, en1_cnt_a, en2_cnt_a, sv0, e1, e2);
        end
        @(negedge clk);
        n_cmp++; if (bus_a.cs_n !== 1'b0) begin n_bad++; $display("FAIL rm_restart: got %b want 0", bus_a.cs_n); end
        s3 = cyc;
        wait_sv_a(150, at, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rm_sv_timeout: got none want pulse"); end
        else begin
            if (at !== s3 + 65) begin n_bad++; $display("FAIL rm_sv_time: got %0d want %0d", at, s3 + 65); end
            e = exp_a.pop_front();
            n_cmp++; if (bus_a.yk !== e) begin n_bad++; $display("FAIL rm_yk_after: got %h want %h", bus_a.yk, e); end
        end
    endtask

    task automatic test_overrun;
        int sb, at; bit ok; logic [15:0] e;
        n_cmp++; if (bus_a.overrun !== 1'b0) begin n_bad++; $display("FAIL a_overrun: got %b want 0", bus_a.overrun); end
        word_b = 16'h0A5A;
        exp_b.push_back(model(12'hA5A));
        reset_b = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus_b.cs_n !== 1'b0) begin n_bad++; $display("FAIL ov_start: got %b want 0", bus_b.cs_n); end
        sb = cyc;
        repeat (49) @(negedge clk);
        n_cmp++; if (bus_b.overrun !== 1'b0) begin n_bad++; $display("FAIL ov_before_tick: got %b want 0", bus_b.overrun); end
        @(negedge clk);
        n_cmp++; if (bus_b.overrun !== 1'b1) begin n_bad++; $display("FAIL ov_at_tick: got %b want 1", bus_b.overrun); end
        wait_sv_b(100, at, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ov_sv_timeout: got none want pulse"); end
        else begin
            if (at !== sb + 65) begin n_bad++; $display("FAIL ov_sv_time: got %0d want %0d", at, sb + 65); end
            e = exp_b.pop_front();
            n_cmp++; if (bus_b.yk !== e) begin n_bad++; $display("FAIL ov_yk: got %h want %h", bus_b.yk, e); end
        end
        word_b = 16'h0333;
        exp_b.push_back(model(12'h333));
        wait_sv_b(150, at, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ov2_sv_timeout: got none want pulse"); end
        else begin
            if (at !== sb + 165) begin n_bad++; $display("FAIL ov2_sv_time: got %0d want %0d", at, sb + 165); end
            e = exp_b.pop_front();
            n_cmp++; if (bus_b.yk !== e) begin n_bad++; $display("FAIL ov2_yk: got %h want %h", bus_b.yk, e); end
        end
        n_cmp++; if (bus_b.overrun !== 1'b1) begin n_bad++; $display("FAIL ov_sticky: got %b want 1", bus_b.overrun); end
        reset_b = 1'b1;
        #1;
        n_cmp++; if (bus_b.overrun !== 1'b0) begin n_bad++; $display("FAIL ov_cleared: got %b want 0", bus_b.overrun); end
    endtask

    initial begin
        test_reset;
        test_midscale;
        test_full_zero;
        test_leading_bits;
        test_reset_mid;
        test_overrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
